// File: rtl/gemvtile_result_collector_pkg.sv
// ---------------------------------------------------------------------------
// gemvtile_result_collector_pkg
//
// Shared definitions for the GEMV tile result collector:
//   - PE_OPERAND_WIDTH / DEFAULT_WORD_WIDTH : result word width of the tile
//   - row_id_width()                        : width of the row tag (min 1)
//   - fifo_entry_t                          : {row, data} FIFO entry at the
//                                             default widths, for consumers
//                                             that sit on the output side
// ---------------------------------------------------------------------------
package gemvtile_result_collector_pkg;

    // Result words are as wide as the PE operands that produced them.
    localparam int PE_OPERAND_WIDTH   = 16;
    localparam int DEFAULT_WORD_WIDTH = PE_OPERAND_WIDTH;
    localparam int DEFAULT_ROW_CNT    = 2;

    // A tag must be at least one bit wide even for a single-row tile.
    function automatic int row_id_width(input int rows);
        return (rows <= 2) ? 1 : $clog2(rows);
    endfunction

    localparam int DEFAULT_ROW_ID_WIDTH = row_id_width(DEFAULT_ROW_CNT);

    typedef struct packed {
        logic [DEFAULT_ROW_ID_WIDTH-1:0] row;
        logic [DEFAULT_WORD_WIDTH-1:0]   data;
    } fifo_entry_t;

endpackage

// File: rtl/gemvtile_result_collector_deser.sv
// ---------------------------------------------------------------------------
// gemvtile_result_collector_deser
//
// One row of the result collector. Assembles LSB-first serial bits into a
// word, parks each finished word in a holding register until the arbiter
// drains it, and flags words that arrive while the holding register is
// still occupied.
//
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   clear      : synchronous flush, same effect as reset
//   bit_in     : serial result bit
//   bit_valid  : qualifies bit_in
//   drain      : arbiter takes hold this edge (pend clears)
//   hold       : last completed word
//   pend       : hold contains a word not yet taken by the arbiter
//   drop       : a completed word is being discarded this edge
// ---------------------------------------------------------------------------
module gemvtile_result_collector_deser
    import gemvtile_result_collector_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    input  logic                  drain,
    output logic [WORD_WIDTH-1:0] hold,
    output logic                  pend,
    output logic                  drop
);

    localparam int BCNT_W = (WORD_WIDTH <= 2) ? 1 : $clog2(WORD_WIDTH);

    logic [WORD_WIDTH-1:0] sreg_reg;
    logic [BCNT_W-1:0]     bcnt_reg;
    logic [WORD_WIDTH-1:0] hold_reg;
    logic                  pend_reg;

    logic [WORD_WIDTH-1:0] word_next;
    logic                  last_bit;
    logic                  accept;

    // Shifting right with the new bit entering at the MSB leaves the first
    // bit of the word in bit 0 once WORD_WIDTH bits have been taken.
    assign word_next = {bit_in, sreg_reg[WORD_WIDTH-1:1]};
    assign last_bit  = bit_valid && (bcnt_reg == BCNT_W'(WORD_WIDTH - 1));

    // A draining holding register frees up on the same edge, so a word that
    // completes right then is still accepted.
    assign accept = last_bit && (!pend_reg || drain);
    assign drop   = last_bit && pend_reg && !drain;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sreg_reg <= '0;
            bcnt_reg <= '0;
            hold_reg <= '0;
            pend_reg <= 1'b0;
        end else if (clear) begin
            sreg_reg <= '0;
            bcnt_reg <= '0;
            hold_reg <= '0;
            pend_reg <= 1'b0;
        end else begin
            if (bit_valid) begin
                sreg_reg <= word_next;
                // Explicit wrap keeps non-power-of-two widths correct.
                bcnt_reg <= last_bit ? '0 : bcnt_reg + 1'b1;
            end
            if (accept) begin
                hold_reg <= word_next;
                pend_reg <= 1'b1;
            end else if (drain) begin
                pend_reg <= 1'b0;
            end
        end
    end

    assign hold = hold_reg;
    assign pend = pend_reg;

endmodule

// File: rtl/gemvtile_result_collector.sv
// ---------------------------------------------------------------------------
// gemvtile_result_collector
//
// Receive side of a GEMV tile's per-row bit-serial result outputs. Each row
// has a deserializer; completed words are arbitrated lowest-row-first into a
// small output FIFO and handed downstream with a valid/ready handshake,
// tagged with the row they came from.
//
// Ports:
//   clk, rstn      : clock, asynchronous active-low reset
//   clear          : synchronous flush of all state
//   serialIn       : one serial result bit per row
//   serialInValid  : per-row qualifier for serialIn
//   outData        : word at the FIFO head
//   outRow         : source row of outData
//   outValid       : FIFO non-empty
//   outReady       : downstream takes the head word when outValid=1
//   overflow       : sticky, a completed word was dropped
// ---------------------------------------------------------------------------
module gemvtile_result_collector
    import gemvtile_result_collector_pkg::*;
#(
    parameter int ROW_CNT      = DEFAULT_ROW_CNT,
    parameter int WORD_WIDTH   = DEFAULT_WORD_WIDTH,
    parameter int FIFO_DEPTH   = 4,
    parameter int ROW_ID_WIDTH = row_id_width(ROW_CNT)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clear,
    input  logic [ROW_CNT-1:0]      serialIn,
    input  logic [ROW_CNT-1:0]      serialInValid,
    output logic [WORD_WIDTH-1:0]   outData,
    output logic [ROW_ID_WIDTH-1:0] outRow,
    output logic                    outValid,
    input  logic                    outReady,
    output logic                    overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Same layout as fifo_entry_t but following this instance's widths.
    typedef struct packed {
        logic [ROW_ID_WIDTH-1:0] row;
        logic [WORD_WIDTH-1:0]   data;
    } entry_t;

    // ---------------------------------------------------------------------
    // Per-row deserializers
    // ---------------------------------------------------------------------
    logic [WORD_WIDTH-1:0] hold [ROW_CNT];
    logic [ROW_CNT-1:0]    pend;
    logic [ROW_CNT-1:0]    drop;
    logic [ROW_CNT-1:0]    grant;

    generate
        for (genvar gi = 0; gi < ROW_CNT; gi++) begin : g_row
            gemvtile_result_collector_deser #(
                .WORD_WIDTH (WORD_WIDTH)
            ) u_deser (
                .clk       (clk),
                .rstn      (rstn),
                .clear     (clear),
                .bit_in    (serialIn[gi]),
                .bit_valid (serialInValid[gi]),
                .drain     (grant[gi]),
                .hold      (hold[gi]),
                .pend      (pend[gi]),
                .drop      (drop[gi])
            );
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Arbiter: lowest pending row wins, one push per cycle
    // ---------------------------------------------------------------------
    logic                    sel_any;
    logic [ROW_ID_WIDTH-1:0] sel_row;
    logic                    fifo_full;
    logic                    push;
    logic                    pop;
    entry_t                  push_entry;

    logic [CNT_W-1:0] count_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    entry_t           mem_reg [FIFO_DEPTH];
    logic             overflow_reg;

    // Scanning downward lets the lowest pending index overwrite the others.
    always_comb begin
        sel_any = 1'b0;
        sel_row = '0;
        for (int i = ROW_CNT - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_any = 1'b1;
                sel_row = ROW_ID_WIDTH'(i);
            end
        end
    end

    // Full blocks a push even when a pop happens on the same edge; this keeps
    // the push decision off the outReady path.
    assign fifo_full = (count_reg == CNT_W'(FIFO_DEPTH));
    assign push      = sel_any && !fifo_full;
    assign pop       = outValid && outReady;

    assign push_entry.row  = sel_row;
    assign push_entry.data = hold[sel_row];

    generate
        for (genvar gi = 0; gi < ROW_CNT; gi++) begin : g_grant
            assign grant[gi] = push && (sel_row == ROW_ID_WIDTH'(gi));
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Output FIFO (register storage, cleared so the idle head reads zero)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= push_entry;
                wr_ptr_reg          <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overflow_reg <= 1'b0;
        end else if (clear) begin
            overflow_reg <= 1'b0;
        end else if (|drop) begin
            overflow_reg <= 1'b1;
        end
    end

    assign outValid = (count_reg != '0);
    assign outData  = mem_reg[rd_ptr_reg].data;
    assign outRow   = mem_reg[rd_ptr_reg].row;
    assign overflow = overflow_reg;

endmodule

// File: doc/gemvtile_result_collector.md
# gemvtile_result_collector

Receive-side companion to the GEMV tile's per-row bit-serial result outputs. One deserializer per PiCaSO row assembles LSB-first serial bits into result words. Completed words are arbitrated (lowest row index first) into a single output FIFO, which hands them downstream through a valid/ready handshake tagged with their row index. It sits between a gemvtile's serialOut/serialOutValid ports and the host-side result sink.

## Interface
- ROW_CNT, 2, number of serial input rows; must equal the tile's PiCaSO row count.
- WORD_WIDTH, 16, bits per result word; matches the PE operand width.
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.
- ROW_ID_WIDTH, $clog2(ROW_CNT) (min 1), width of the row tag.
- clk  in  1  sole clock; all state on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush of all state, same effect as reset.
- serialIn[ROW_CNT]  in  1 each  serial result bit per row.
- serialInValid[ROW_CNT]  in  1 each  qualifies serialIn of the same row.
- outData  out  WORD_WIDTH  word at the FIFO head.
- outRow  out  ROW_ID_WIDTH  source row of outData.
- outValid  out  1  FIFO non-empty.
- outReady  in  1  downstream accepts the head word when outValid=1.
- overflow  out  1  sticky: a word was dropped.

## Operation
- Deserializer per row: shift register sreg and bit counter bcnt (0..WORD_WIDTH-1).
  - Each edge with serialInValid[r]=1: the bit is shifted in LSB-first; the first bit lands in bit 0 of the final word.
  - bcnt increments on each accepted bit and wraps to 0.
  - Gaps (valid=0) hold sreg and bcnt; no timeout.
- On the bit where bcnt==WORD_WIDTH-1, the assembled word is written into the row's holding register hold[r] and pend[r] is set.
  - If pend[r] is already 1 and hold[r] is not being drained that same edge, the new word is dropped and overflow is set (sticky until reset/clear). hold[r] keeps the older word.
  - If hold[r] is drained that same edge, the new word is accepted and no overflow occurs.
- Arbiter: each cycle the lowest r with pend[r]=1 is selected. If the FIFO is not full, {r, hold[r]} is pushed and pend[r] is cleared. One push per cycle.
- FIFO:
  - outValid = !empty; outData/outRow are the head entry.
  - A pop occurs on outValid&&outReady.
  - Push is blocked whenever the FIFO is full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle when not full are both performed; the count is unchanged.
- While the FIFO is full, pending words wait in hold[]. Further completions on those rows then overflow per the rule above.
- clear=1 (synchronous) and rstn=0 (asynchronous) have the same effect:
  - bcnt=0, sreg=0, pend=0, hold=0;
  - FIFO empty, outValid=0, outData=0, outRow=0, overflow=0.
  - clear wins over any simultaneous bit, push or pop.
  - A reset in the middle of a word discards the partial bits.

## Timing
- Final bit sampled at edge k: pend[r]=1 after edge k, FIFO push at edge k+1, outValid=1 after edge k+1. Latency is 2 cycles from last-bit presentation, with no contention and a non-full FIFO.
- Each additional simultaneously pending lower-index row adds 1 cycle.
- The FIFO head updates on the edge following a pop.
- Sustained throughput is 1 word/cycle total. Per-row input rate (1 word per WORD_WIDTH cycles) is always below the drain rate when outReady=1.
- All outputs are registered or derived directly from registered FIFO pointers and storage; no combinational path from serialIn to any output.

## Structure
- Shared package holds:
  - WORD_WIDTH default tied to the PE operand width;
  - the FIFO entry struct {row, data};
  - the row-ID width helper.
- Sub-module _result_collector_deser: one row's sreg/bcnt/hold/pend and drop detection, instantiated ROW_CNT times in a generate loop.
- The arbiter and FIFO stay in the top module; the FIFO uses plain register storage.

## Test plan
- Reset/idle:
  - Hold rstn=0 → outValid=0, outData=0, overflow=0.
  - Release with no valid bits for 50 cycles → outputs unchanged.
- Single word, WORD_WIDTH=16, row 1:
  - Stream 0xA5C3 LSB-first, valid every cycle, outReady=1.
  - Required: outValid rises exactly 2 cycles after the last bit, outData=0xA5C3, outRow=1; popped next edge.
- Gapped input, row 0:
  - Send 0x0001 with valid toggling 1,0,1,0.
  - Required: outData=0x0001, outRow=0; no spurious word.
- Simultaneous completion:
  - Rows 0 and 1 finish 0x1111/0x2222 on the same edge.
  - Required: row 0 is output first, row 1 one cycle later; no overflow.
- Backpressure/overflow, FIFO_DEPTH=4:
  - outReady=0; send 5 words on row 0, then 1 more.
  - Required: FIFO holds words 1–4, hold holds word 5, the 6th word is dropped and overflow=1.
  - Then outReady=1: words 1–5 emerge in order.
- Mid-word clear:
  - After 7 bits on row 0, pulse clear; then send 0xBEEF.
  - Required: only 0xBEEF is output; overflow=0.
